dds_sweep_ctrl: RTL
===================

DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 Parameter FREQ_WORD_WIDTH, default 8: width of the frequency tuning word.
REQ-002 Parameter PHASE_WORD_WIDTH, default 8: width of the ROM address and the phase offset.
REQ-003 Parameter ACC_WIDTH, default 16: width of the phase accumulator, which SHALL be at least PHASE_WORD_WIDTH + FREQ_WORD_WIDTH.
REQ-004 clk  in  1: single reference clock; all logic is on the rising edge.
REQ-005 rst  in  1: asynchronous, active-high reset.
REQ-006 cfg_we  in  1: configuration write strobe, one cycle per write.
REQ-007 cfg_addr  in  3: register select: 0 start_fw, 1 stop_fw, 2 step_fw, 3 dwell, 4 phase_off, 5 {mode[1:0], sel[1:0]}.
REQ-008 cfg_wdata  in  16: write data, LSB-aligned; unused upper bits are ignored.
REQ-009 start  in  1: single-cycle command pulse that begins generation.
REQ-010 stop  in  1: single-cycle command pulse that aborts generation.
REQ-011 rom_en  out  1: wave ROM enable.
REQ-012 rom_addr  out  PHASE_WORD_WIDTH: wave ROM address.
REQ-013 rom_sel  out  2: waveform select (0 cos, 1 tri, 2 pulse, 3 awg).
REQ-014 busy  out  1: high in every state except IDLE.
REQ-015 sweep_done  out  1: one-cycle pulse marking the end of a sweep.
REQ-016 cur_fw  out  FREQ_WORD_WIDTH: current frequency word.

Function
REQ-017 The FSM SHALL have the states IDLE, RUN and HOLD, and all outputs SHALL be registered.
REQ-018 Accumulator: in RUN and HOLD, acc <= acc + cur_fw every cycle, modulo 2^ACC_WIDTH; the accumulator SHALL hold its value in IDLE.
REQ-019 rom_addr SHALL equal acc[ACC_WIDTH-1 -: PHASE_WORD_WIDTH] + phase_off, modulo 2^PHASE_WORD_WIDTH, registered one cycle after the acc update.
REQ-020 Modes: 0 = fixed tone at start_fw; 1 = single sweep, ending in HOLD; 2 = continuous sweep; mode 3 SHALL behave as mode 0.
REQ-021 A start pulse in IDLE SHALL load acc=0, cur_fw=start_fw and dwell_cnt=0, and enter RUN; rom_en and busy SHALL go high on the next clock edge.
REQ-022 A start pulse outside IDLE SHALL be ignored.
REQ-023 A stop pulse in any state SHALL return the FSM to IDLE on the next edge, with rom_en=0 and busy=0.
REQ-024 When start and stop are asserted in the same cycle, stop SHALL win.
REQ-025 Sweep in RUN (modes 1 and 2): dwell_cnt SHALL increment each cycle; when dwell_cnt==dwell, dwell_cnt SHALL clear and a step evaluation SHALL occur; dwell=0 means a step evaluation every cycle.
REQ-026 Step evaluation SHALL compute sum = cur_fw + step_fw at FREQ_WORD_WIDTH+1 bits; if sum <= stop_fw, cur_fw SHALL be set to sum.
REQ-027 If sum > stop_fw in mode 1, cur_fw SHALL be set to stop_fw, sweep_done SHALL pulse, and the FSM SHALL enter HOLD (tone continues; exit only by stop).
REQ-028 If sum > stop_fw in mode 2, cur_fw SHALL be set to start_fw, sweep_done SHALL pulse, and the FSM SHALL remain in RUN.
REQ-029 If start_fw > stop_fw, the first step evaluation SHALL take the end-of-sweep path.
REQ-030 If step_fw=0, cur_fw SHALL never change and sweep_done SHALL never fire.
REQ-031 Config writes SHALL take effect on the next edge in every state, except that start_fw takes effect only at the next start or wrap, and a running cur_fw is not reloaded by writes.
REQ-032 A write to mode in RUN or HOLD SHALL be applied only on the next return to IDLE.
REQ-033 sel changes in RUN or HOLD SHALL be staged and copied to rom_sel only in the cycle in which the accumulator carries out (wraps); in IDLE, rom_sel SHALL update on the next edge.
REQ-034 A cfg write coinciding with a start SHALL be applied first, so the start uses the new value.

Reset
REQ-035 Asserting rst SHALL asynchronously force the state to IDLE and clear acc, dwell_cnt, cur_fw, rom_en, rom_addr, rom_sel, busy and sweep_done.
REQ-036 Reset SHALL set the config registers to start_fw=0, stop_fw=all ones, step_fw=1, dwell=0, phase_off=0, mode=0 and sel=0.
REQ-037 Reset asserted mid-sweep SHALL abort immediately, and the block SHALL await a new start after release.

Verification
REQ-038 Tone: mode 0, start_fw=0x40, phase_off=0, start -> rom_addr sequence 0,0,0,0,1,1,1,1,2,..., rom_en=1 and busy=1 from the cycle after start.
REQ-039 Single sweep: start_fw=0x10, stop_fw=0x30, step_fw=0x10, dwell=3, mode 1 -> cur_fw 0x10 for 4 cycles, then 0x20, then 0x30; at the next evaluation sweep_done pulses once and the FSM holds 0x30 in HOLD.
REQ-040 Continuous sweep: start_fw=0xF0, stop_fw=0xFF, step_fw=0x20, dwell=0, mode 2 -> the 9-bit sum 0x110 > 0xFF, so cur_fw returns to 0xF0 with sweep_done high every cycle.
REQ-041 Simultaneous start+stop in IDLE -> the FSM stays in IDLE with busy=0; stop mid-RUN -> rom_en=0 on the next edge and acc is frozen.
REQ-042 Writing sel=2 in RUN with cur_fw=0x80 and ACC_WIDTH=16 -> rom_sel changes only in the cycle in which the accumulator wraps past 0xFFFF, and not before.
REQ-043 rst pulse mid-sweep -> all outputs are 0 asynchronously; after release, a start with the default config produces tone 0 (start_fw=0), and rom_addr stays at 0.

Source files
------------

// File: rtl/dds_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// dds_sweep_ctrl
// Direct digital synthesis sweep controller. A phase accumulator, advanced by
// the current frequency word, addresses a wave ROM. The frequency word can be
// held fixed (tone), stepped once from start_fw up to stop_fw (single sweep,
// ending in HOLD), or stepped repeatedly (continuous sweep). The waveform
// select is re-timed to an accumulator wrap while generating, so a waveform
// change always lands on a period boundary.
// -----------------------------------------------------------------------------
module dds_sweep_ctrl #(
    parameter int FREQ_WORD_WIDTH  = 8,
    parameter int PHASE_WORD_WIDTH = 8,
    parameter int ACC_WIDTH        = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_we,
    input  logic [2:0]                  cfg_addr,
    input  logic [15:0]                 cfg_wdata,
    input  logic                        start,
    input  logic                        stop,
    output logic                        rom_en,
    output logic [PHASE_WORD_WIDTH-1:0] rom_addr,
    output logic [1:0]                  rom_sel,
    output logic                        busy,
    output logic                        sweep_done,
    output logic [FREQ_WORD_WIDTH-1:0]  cur_fw
);

    localparam int FW = FREQ_WORD_WIDTH;
    localparam int PW = PHASE_WORD_WIDTH;
    localparam int AW = ACC_WIDTH;
    localparam int DW = 16;

    // Register map
    localparam logic [2:0] ADDR_START_FW  = 3'd0;
    localparam logic [2:0] ADDR_STOP_FW   = 3'd1;
    localparam logic [2:0] ADDR_STEP_FW   = 3'd2;
    localparam logic [2:0] ADDR_DWELL     = 3'd3;
    localparam logic [2:0] ADDR_PHASE_OFF = 3'd4;
    localparam logic [2:0] ADDR_MODE_SEL  = 3'd5;

    // Operating modes (mode 3 is treated like a fixed tone)
    localparam logic [1:0] MODE_SINGLE = 2'd1;
    localparam logic [1:0] MODE_CONT   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Configuration registers
    logic [FW-1:0] start_fw_r;
    logic [FW-1:0] stop_fw_r;
    logic [FW-1:0] step_fw_r;
    logic [DW-1:0] dwell_r;
    logic [PW-1:0] phase_off_r;
    logic [1:0]    mode_r;
    logic [1:0]    sel_r;

    // Datapath / FSM state
    state_t        state_r;
    logic [1:0]    mode_run_r;
    logic [AW-1:0] acc_r;
    logic [DW-1:0] dwell_cnt_r;
    logic [FW-1:0] cur_fw_r;
    logic          rom_en_r;
    logic [PW-1:0] rom_addr_r;
    logic [1:0]    rom_sel_r;
    logic          busy_r;
    logic          sweep_done_r;

    // Combinational helpers
    logic          wr_start_fw_s;
    logic          wr_phase_off_s;
    logic          wr_mode_sel_s;
    logic [FW-1:0] start_fw_eff_s;
    logic [PW-1:0] phase_off_eff_s;
    logic [1:0]    mode_eff_s;
    logic [1:0]    sel_eff_s;
    logic [AW:0]   acc_sum_s;
    logic          acc_carry_s;
    logic [PW-1:0] phase_s;
    logic [FW:0]   fw_sum_s;
    logic          fw_over_s;
    logic          dwell_hit_s;
    logic          sweep_mode_s;
    logic          step_nonzero_s;

    // Write decode and write-through views of the config, so a write in the
    // same cycle as start is what the start actually uses
    always_comb begin
        wr_start_fw_s   = cfg_we && (cfg_addr == ADDR_START_FW);
        wr_phase_off_s  = cfg_we && (cfg_addr == ADDR_PHASE_OFF);
        wr_mode_sel_s   = cfg_we && (cfg_addr == ADDR_MODE_SEL);
        start_fw_eff_s  = start_fw_r;
        phase_off_eff_s = phase_off_r;
        mode_eff_s      = mode_r;
        sel_eff_s       = sel_r;
        if (wr_start_fw_s) begin
            start_fw_eff_s = cfg_wdata[FW-1:0];
        end else begin
            start_fw_eff_s = start_fw_r;
        end
        if (wr_phase_off_s) begin
            phase_off_eff_s = cfg_wdata[PW-1:0];
        end else begin
            phase_off_eff_s = phase_off_r;
        end
        if (wr_mode_sel_s) begin
            mode_eff_s = cfg_wdata[3:2];
            sel_eff_s  = cfg_wdata[1:0];
        end else begin
            mode_eff_s = mode_r;
            sel_eff_s  = sel_r;
        end
    end

    // Accumulator advance, ROM phase and sweep step arithmetic
    always_comb begin
        acc_sum_s      = {1'b0, acc_r} + {{(AW + 1 - FW){1'b0}}, cur_fw_r};
        acc_carry_s    = acc_sum_s[AW];
        phase_s        = acc_r[AW-1 -: PW] + phase_off_r;
        fw_sum_s       = {1'b0, cur_fw_r} + {1'b0, step_fw_r};
        fw_over_s      = (fw_sum_s > {1'b0, stop_fw_r});
        dwell_hit_s    = (dwell_cnt_r == dwell_r);
        sweep_mode_s   = (mode_run_r == MODE_SINGLE) || (mode_run_r == MODE_CONT);
        step_nonzero_s = (step_fw_r != {FW{1'b0}});
    end

    // Configuration register file; written in every state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_fw_r  <= {FW{1'b0}};
            stop_fw_r   <= {FW{1'b1}};
            step_fw_r   <= {{(FW - 1){1'b0}}, 1'b1};
            dwell_r     <= {DW{1'b0}};
            phase_off_r <= {PW{1'b0}};
            mode_r      <= 2'd0;
            sel_r       <= 2'd0;
        end else if (cfg_we) begin
            case (cfg_addr)
                ADDR_START_FW:  start_fw_r  <= cfg_wdata[FW-1:0];
                ADDR_STOP_FW:   stop_fw_r   <= cfg_wdata[FW-1:0];
                ADDR_STEP_FW:   step_fw_r   <= cfg_wdata[FW-1:0];
                ADDR_DWELL:     dwell_r     <= cfg_wdata[DW-1:0];
                ADDR_PHASE_OFF: phase_off_r <= cfg_wdata[PW-1:0];
                ADDR_MODE_SEL: begin
                    mode_r <= cfg_wdata[3:2];
                    sel_r  <= cfg_wdata[1:0];
                end
                default: begin
                    start_fw_r <= start_fw_r;
                end
            endcase
        end else begin
            start_fw_r <= start_fw_r;
        end
    end

    // Control FSM with accumulator, sweep stepping and registered outputs.
    // The mode is captured at start, so mode writes while generating only
    // matter after the next return to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            mode_run_r   <= 2'd0;
            acc_r        <= {AW{1'b0}};
            dwell_cnt_r  <= {DW{1'b0}};
            cur_fw_r     <= {FW{1'b0}};
            rom_en_r     <= 1'b0;
            rom_addr_r   <= {PW{1'b0}};
            rom_sel_r    <= 2'd0;
            busy_r       <= 1'b0;
            sweep_done_r <= 1'b0;
        end else begin
            sweep_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    rom_sel_r <= sel_eff_s;
                    if (stop) begin
                        rom_en_r <= 1'b0;
                        busy_r   <= 1'b0;
                    end else if (start) begin
                        state_r     <= ST_RUN;
                        mode_run_r  <= mode_eff_s;
                        acc_r       <= {AW{1'b0}};
                        dwell_cnt_r <= {DW{1'b0}};
                        cur_fw_r    <= start_fw_eff_s;
                        rom_addr_r  <= phase_off_eff_s;
                        rom_en_r    <= 1'b1;
                        busy_r      <= 1'b1;
                    end else begin
                        rom_en_r <= 1'b0;
                        busy_r   <= 1'b0;
                    end
                end

                ST_RUN, ST_HOLD: begin
                    if (stop) begin
                        state_r  <= ST_IDLE;
                        rom_en_r <= 1'b0;
                        busy_r   <= 1'b0;
                    end else begin
                        acc_r      <= acc_sum_s[AW-1:0];
                        rom_addr_r <= phase_s;
                        rom_en_r   <= 1'b1;
                        busy_r     <= 1'b1;
                        // Waveform changes only land on a period boundary
                        if (acc_carry_s) begin
                            rom_sel_r <= sel_r;
                        end
                        if ((state_r == ST_RUN) && sweep_mode_s) begin
                            if (dwell_hit_s) begin
                                dwell_cnt_r <= {DW{1'b0}};
                                // A zero step never moves the tone nor ends a sweep
                                if (step_nonzero_s) begin
                                    if (!fw_over_s) begin
                                        cur_fw_r <= fw_sum_s[FW-1:0];
                                    end else if (mode_run_r == MODE_SINGLE) begin
                                        cur_fw_r     <= stop_fw_r;
                                        sweep_done_r <= 1'b1;
                                        state_r      <= ST_HOLD;
                                    end else begin
                                        cur_fw_r     <= start_fw_r;
                                        sweep_done_r <= 1'b1;
                                    end
                                end
                            end else begin
                                dwell_cnt_r <= dwell_cnt_r + {{(DW - 1){1'b0}}, 1'b1};
                            end
                        end
                    end
                end

                default: begin
                    state_r  <= ST_IDLE;
                    rom_en_r <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign rom_en     = rom_en_r;
    assign rom_addr   = rom_addr_r;
    assign rom_sel    = rom_sel_r;
    assign busy       = busy_r;
    assign sweep_done = sweep_done_r;
    assign cur_fw     = cur_fw_r;

endmodule
